// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter and instruction-fetch front end.
// Issues one request at a time to instruction memory, holds the returned
// word for decode, and handles redirects by discarding in-flight data.
module pc_fetch_ctrl #(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         DATA_W    = 32,
  parameter logic [ADDR_W-1:0]   RESET_VEC = 32'hBFC0_0000,
  parameter int unsigned         STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              fetch_adel
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] fetch_inst_q, fetch_inst_d;
  logic              fetch_adel_q, fetch_adel_d;
  logic              pc_aligned;

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_VEC;
      req_pc_q     <= RESET_VEC;
      discard_q    <= 1'b0;
      fetch_pc_q   <= RESET_VEC;
      fetch_inst_q <= '0;
      fetch_adel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      discard_q    <= discard_d;
      fetch_pc_q   <= fetch_pc_d;
      fetch_inst_q <= fetch_inst_d;
      fetch_adel_q <= fetch_adel_d;
    end
  end

  // Next-state, PC update and request generation; redirect overrides all.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    discard_d    = discard_q;
    fetch_pc_d   = fetch_pc_q;
    fetch_inst_d = fetch_inst_q;
    fetch_adel_d = fetch_adel_q;
    inst_req     = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (pc_aligned) begin
          inst_req = 1'b1;
          if (inst_addr_ok) begin
            state_d   = S_WAIT;
            req_pc_d  = pc_q;
            // Accepted request already targets the old PC: its data is stale.
            discard_d = redir_valid;
          end
        end else if (!redir_valid) begin
          state_d      = S_HOLD;
          fetch_pc_d   = pc_q;
          fetch_inst_d = '0;
          fetch_adel_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d   = S_REQ;
          discard_d = 1'b0;
          if (!discard_q && !redir_valid) begin
            state_d      = S_HOLD;
            fetch_pc_d   = req_pc_q;
            fetch_inst_d = inst_rdata;
            fetch_adel_d = 1'b0;
          end
        end else if (redir_valid) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir_valid) begin
          state_d = S_REQ;
        end else if (en) begin
          state_d = S_REQ;
          pc_d    = fetch_pc_q + ADDR_W'(STEP);
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (redir_valid) begin
      pc_d = redir_pc;
    end
  end

  assign inst_addr   = pc_q;
  assign fetch_valid = (state_q == S_HOLD);
  assign fetch_pc    = fetch_pc_q;
  assign fetch_inst  = fetch_inst_q;
  assign fetch_adel  = fetch_valid & fetch_adel_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the fetch front end.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam logic [31:0] STEP = 32'd4;

  logic        clk = 1'b0;
  logic        rst, en, redir_valid, inst_addr_ok, inst_data_ok;
  logic [31:0] redir_pc, inst_rdata;
  logic        inst_req, fetch_valid, fetch_adel;
  logic [31:0] inst_addr, fetch_pc, fetch_inst;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: the PC, whether a request is in flight (and whether its data is
  // stale), and the entry currently offered to decode.
  logic [31:0] m_pc, m_req_pc, m_hpc, m_hinst;
  bit          m_out, m_stale, m_held, m_hadel;

  // Memory responder: one pending read with a random latency.
  bit          mem_pend;
  int unsigned mem_lat;
  logic [31:0] mem_addr;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_VEC(32'hBFC0_0000),
    .STEP     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_inst  (fetch_inst),
    .fetch_adel  (fetch_adel)
  );

  function automatic bit exp_req();
    return !m_out && !m_held && (m_pc[1:0] == 2'b00);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_edge();
    logic [31:0] o_pc;
    bit o_req, o_out, o_held, issued, returned;
    o_pc   = m_pc;
    o_req  = exp_req();
    o_out  = m_out;
    o_held = m_held;
    if (rst) begin
      m_pc = RV; m_out = 0; m_stale = 0; m_held = 0;
      m_hpc = RV; m_hinst = '0; m_hadel = 0; mem_pend = 0;
      return;
    end
    issued   = o_req && inst_addr_ok;
    returned = o_out && inst_data_ok;
    if (returned) begin
      if (!m_stale && !redir_valid) begin
        m_held = 1; m_hpc = m_req_pc; m_hinst = inst_rdata; m_hadel = 0;
      end
      m_out = 0; m_stale = 0;
    end
    if (issued) begin
      m_out = 1; m_req_pc = o_pc; m_stale = redir_valid;
    end
    if (redir_valid) begin
      m_held = 0;
      if (o_out && !returned) m_stale = 1;
      m_pc = redir_pc;
    end else if (o_held && en) begin
      m_held = 0;
      m_pc = m_hpc + STEP;
    end else if (!o_out && !o_held && o_pc[1:0] != 2'b00) begin
      m_held = 1; m_hpc = o_pc; m_hinst = '0; m_hadel = 1;
    end
    if (issued) begin
      mem_pend = 1; mem_addr = o_pc; mem_lat = $urandom_range(0, 3);
    end else if (mem_pend && inst_data_ok) begin
      mem_pend = 0;
    end else if (mem_pend && mem_lat > 0) begin
      mem_lat--;
    end
  endtask

  task automatic check_all();
    chk("inst_req", 64'(inst_req), 64'(exp_req()));
    chk("inst_addr", 64'(inst_addr), 64'(m_pc));
    chk("fetch_valid", 64'(fetch_valid), 64'(m_held));
    chk("fetch_adel", 64'(fetch_adel), 64'(m_held && m_hadel));
    if (m_held) begin
      chk("fetch_pc", 64'(fetch_pc), 64'(m_hpc));
      chk("fetch_inst", 64'(fetch_inst), 64'(m_hinst));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; en = 0; redir_valid = 0; redir_pc = '0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    m_pc = RV; m_req_pc = RV; m_hpc = RV; m_hinst = '0;
    m_out = 0; m_stale = 0; m_held = 0; m_hadel = 0;
    mem_pend = 0; mem_lat = 0; mem_addr = '0;
    #2;

    // Reset and first cycle after it
    cyc();
    rst = 0;
    chk("rst_req", 64'(inst_req), 64'd1);
    chk("rst_addr", 64'(inst_addr), 64'hBFC0_0000);
    chk("rst_valid", 64'(fetch_valid), 64'd0);

    // Basic fetch: addr_ok at cycle 1, data_ok at cycle 3, valid at cycle 4
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; cyc();
    inst_data_ok = 1; inst_rdata = 32'h2408_0001; cyc();
    inst_data_ok = 0;
    chk("basic_valid", 64'(fetch_valid), 64'd1);
    chk("basic_pc", 64'(fetch_pc), 64'hBFC0_0000);
    chk("basic_inst", 64'(fetch_inst), 64'h2408_0001);

    // Stall in HOLD for 5 cycles
    en = 0;
    repeat (5) begin
      cyc();
      chk("stall_valid", 64'(fetch_valid), 64'd1);
      chk("stall_pc", 64'(fetch_pc), 64'hBFC0_0000);
      chk("stall_inst", 64'(fetch_inst), 64'h2408_0001);
      chk("stall_req", 64'(inst_req), 64'd0);
    end
    en = 1; cyc(); en = 0;
    chk("seq_addr", 64'(inst_addr), 64'hBFC0_0004);
    chk("seq_req", 64'(inst_req), 64'd1);

    // Redirect while waiting: returned data must be dropped
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; redir_valid = 1; redir_pc = 32'hBFC0_0380; cyc();
    redir_valid = 0; cyc();
    inst_data_ok = 1; inst_rdata = 32'hDEAD_BEEF; cyc();
    inst_data_ok = 0;
    chk("drop_valid", 64'(fetch_valid), 64'd0);
    chk("drop_addr", 64'(inst_addr), 64'hBFC0_0380);
    chk("drop_req", 64'(inst_req), 64'd1);

    // Redirect and en together in HOLD: redirect wins
    redir_valid = 1; redir_pc = 32'hBFC0_0010; cyc();
    redir_valid = 0; inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h1111_2222; cyc();
    inst_data_ok = 0;
    chk("prio_hold_pc", 64'(fetch_pc), 64'hBFC0_0010);
    redir_valid = 1; en = 1; redir_pc = 32'h8000_1000; cyc();
    redir_valid = 0; en = 0;
    chk("prio_addr", 64'(inst_addr), 64'h8000_1000);
    chk("prio_valid", 64'(fetch_valid), 64'd0);

    // Misaligned redirect: no request, address-error entry held
    redir_valid = 1; redir_pc = 32'h8000_0002; cyc();
    redir_valid = 0;
    chk("adel_noreq", 64'(inst_req), 64'd0);
    cyc();
    chk("adel_valid", 64'(fetch_valid), 64'd1);
    chk("adel_flag", 64'(fetch_adel), 64'd1);
    chk("adel_pc", 64'(fetch_pc), 64'h8000_0002);
    chk("adel_inst", 64'(fetch_inst), 64'd0);
    redir_valid = 1; redir_pc = 32'hBFC0_0000; cyc();
    redir_valid = 0;

    // Reset during WAIT
    inst_addr_ok = 1; cyc();
    inst_addr_ok = 0; rst = 1; cyc();
    rst = 0;
    chk("rstw_req", 64'(inst_req), 64'd1);
    chk("rstw_addr", 64'(inst_addr), 64'hBFC0_0000);
    chk("rstw_valid", 64'(fetch_valid), 64'd0);

    // Randomized traffic
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel;
      rst = ($urandom_range(0, 149) == 0);
      redir_valid = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 15);
      if (sel == 0)      redir_pc = ($urandom & ~32'h3) | 32'($urandom_range(1, 3));
      else if (sel == 1) redir_pc = 32'hFFFF_FFFC;
      else               redir_pc = $urandom & ~32'h3;
      en = $urandom_range(0, 1) == 1;
      inst_addr_ok = $urandom_range(0, 1) == 1;
      if (mem_pend) begin
        inst_data_ok = (mem_lat == 0);
        inst_rdata   = {mem_addr[15:0], ~mem_addr[31:16]};
      end else begin
        inst_data_ok = ($urandom_range(0, 7) == 0);
        inst_rdata   = $urandom;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
